// File: rtl/decoder_5bit_if.sv
// ============================================================================
// Module  : decoder_5bit_if
// Brief   : Address/enable in, one-hot select/valid out for decoder_5bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface decoder_5bit_if;
    logic [5:1]  in;
    logic        en;
    logic [32:1] out;
    logic        valid;

    modport master (
        output in,
        output en,
        input  out,
        input  valid
    );

    modport slave (
        input  in,
        input  en,
        output out,
        output valid
    );
endinterface

`default_nettype wire

// File: rtl/decoder_5bit.sv
// ============================================================================
// Module  : decoder_5bit
// Brief   : 5-to-32 one-hot register-select decoder with enable and valid.
//           Define DECODER_5BIT_REG_OUT_EN to register the outputs (1 cycle).
// Revision: 1.0
// ============================================================================
`default_nettype none

module decoder_5bit (
    input  wire            clk,
    input  wire            rst_n,
    decoder_5bit_if.slave  bus
);

    logic [32:1] d;

    // Line j is selected by address j-1; X on the address stays X on the lines.
    for (genvar j = 1; j <= 32; j++) begin : g_line
        assign d[j] = bus.en & (bus.in == 5'(j - 1));
    end

`ifdef DECODER_5BIT_REG_OUT_EN
    logic [32:1] out_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= d;
            valid_q <= bus.en;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign bus.out   = d;
    assign bus.valid = bus.en;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder_5bit.sv
// ============================================================================
// Module  : tb_decoder_5bit
// Brief   : Scoreboard bench for decoder_5bit (either build of the outputs).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decoder_5bit;

`ifdef DECODER_5BIT_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [32:1] out;
        logic        valid;
        int          due;
        int          tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   tag_n;
    exp_t q[$];
    exp_t mon_e;

    decoder_5bit_if bus ();

    decoder_5bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_e.due < cyc) begin
                errors++;
                $display("FAIL stale#%0d: expectation due at cycle %0d not checked (now %0d)",
                         mon_e.tag, mon_e.due, cyc);
            end else if (bus.out !== mon_e.out || bus.valid !== mon_e.valid) begin
                errors++;
                $display("FAIL dec#%0d: got out=%h valid=%b, expected out=%h valid=%b",
                         mon_e.tag, bus.out, bus.valid, mon_e.out, mon_e.valid);
            end
        end
    end

    task automatic drive_exp(input logic [4:0] a, input logic e,
                             input logic [31:0] exp_out, input logic exp_valid);
        exp_t x;
        @(posedge clk);
        #1;
        bus.in = a;
        bus.en = e;
        x.out   = exp_out;
        x.valid = exp_valid;
        x.due   = cyc + LAT;
        x.tag   = tag_n++;
        q.push_back(x);
    endtask

    task automatic drive(input logic [4:0] a, input logic e);
        logic [31:0] one;
        one = 32'h1;
        drive_exp(a, e, e ? (one << a) : 32'h0, e);
    endtask

    task automatic direct_check(input string name, input logic [31:0] exp_out,
                                input logic exp_valid);
        checks++;
        if (bus.out !== exp_out || bus.valid !== exp_valid) begin
            errors++;
            $display("FAIL %s: got out=%h valid=%b, expected out=%h valid=%b",
                     name, bus.out, bus.valid, exp_out, exp_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tag_n  = 0;
        rst_n  = 1'b0;
        bus.in = 5'd0;
        bus.en = 1'b0;
        #3;
        direct_check("reset_state", 32'h0, 1'b0);
        #4;
        rst_n = 1'b1;

        for (int k = 0; k < 32; k++) drive(5'(k), 1'b1);

        drive_exp(5'd4,  1'b1, 32'h0000_0010, 1'b1);
        drive_exp(5'd4,  1'b0, 32'h0000_0000, 1'b0);
        drive_exp(5'd4,  1'b1, 32'h0000_0010, 1'b1);
        drive_exp(5'd0,  1'b1, 32'h0000_0001, 1'b1);
        drive_exp(5'd31, 1'b1, 32'h8000_0000, 1'b1);
        drive_exp(5'd31, 1'b0, 32'h0000_0000, 1'b0);
        drive_exp(5'd9,  1'b1, 32'h0000_0200, 1'b1);
        drive_exp(5'd9,  1'b1, 32'h0000_0200, 1'b1);
        drive_exp(5'd9,  1'b1, 32'h0000_0200, 1'b1);

`ifdef DECODER_5BIT_REG_OUT_EN
        drive_exp(5'd3,  1'b1, 32'h0000_0008, 1'b1);
        drive_exp(5'd7,  1'b1, 32'h0000_0080, 1'b1);
        drive_exp(5'd12, 1'b1, 32'h0000_1000, 1'b1);
        @(posedge clk);
        #1;
        bus.in = 5'd20;
        bus.en = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        direct_check("async_reset", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        direct_check("reset_drops_inflight", 32'h0, 1'b0);
        rst_n  = 1'b1;
        bus.in = 5'd2;
        bus.en = 1'b1;
        begin
            exp_t x;
            x.out   = 32'h0000_0004;
            x.valid = 1'b1;
            x.due   = cyc + 1;
            x.tag   = tag_n++;
            q.push_back(x);
        end
`endif

        for (int i = 0; i < 1000; i++)
            drive(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

        @(posedge clk);
        #1;
        bus.en = 1'b0;
        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
